// File: rtl/vc_router_pkg.sv
// Shared definitions for the VC-to-destination router.
//   ARB_MODE_PRIO / ARB_MODE_RR : arbitration mode selectors
//   clog2()                     : pointer width helper (never returns 0)
package vc_router_pkg;

  localparam int ARB_MODE_PRIO = 0;
  localparam int ARB_MODE_RR   = 1;

  // Bits needed to index 'value' entries. The result is at least 1, so a
  // pointer is never zero-width.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    return (result == 0) ? 1 : result;
  endfunction

endpackage

// File: rtl/vc_dest_router_rr_arbiter.sv
// Single-destination arbiter, purely combinational.
//   req      in  N      requesting VCs
//   ptr      in  PTR_W  registered round-robin pointer (ignored in priority mode)
//   grant    out N      one-hot grant, all zero when nothing requests
//   next_ptr out PTR_W  winner+1 wrapped, or ptr unchanged when there is no grant
module rr_arbiter
  import vc_router_pkg::*;
#(
  parameter int N    = 2,
  parameter int MODE = ARB_MODE_PRIO,
  localparam int PTR_W = clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [PTR_W-1:0] next_ptr
);

  always_comb begin
    int  start;
    int  idx;
    logic found;
    // NOTE: every combinational output gets a default before any branch;
    // otherwise an untaken path would hold its value and infer a latch.
    grant    = '0;
    next_ptr = ptr;
    found    = 1'b0;
    idx      = 0;
    start    = (MODE == ARB_MODE_RR) ? int'(ptr) : 0;
    // Scan N slots beginning at 'start'; the first requester found wins.
    for (int off = 0; off < N; off++) begin
      idx = (start + off) % N;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        next_ptr   = (idx == N - 1) ? '0 : PTR_W'(idx + 1);
      end
    end
  end

endmodule

// File: rtl/vc_dest_router.sv
// Steers head-of-line words from NUM_VC show-ahead VC FIFOs to NUM_DEST
// destination FIFOs, selected by a field inside each word.
//   clk, reset  rising-edge clock, synchronous active-high reset
//   vc_data     head word per VC, VC i at [i*DATA_W +: DATA_W]
//   vc_empty    VC FIFO empty flags
//   vc_pop      combinational pop strobes (forced low during reset)
//   dest_afull  destination almost-full flags, sampled in the grant cycle
//   dest_data   registered word per destination, held when not pushing
//   dest_push   registered push strobe per destination
//   err_pulse   registered one-cycle pulse per VC whose word was dropped
//   err_sticky  set by any drop, cleared only by reset
//   drop_count  saturating count of dropped words
module vc_dest_router
  import vc_router_pkg::*;
#(
  parameter int DATA_W   = 6,
  parameter int NUM_VC   = 2,
  parameter int NUM_DEST = 2,
  parameter int DEST_LSB = 4,
  parameter int DEST_W   = 1,
  parameter int ARB_MODE = ARB_MODE_PRIO,
  parameter int CNT_W    = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_VC*DATA_W-1:0]   vc_data,
  input  logic [NUM_VC-1:0]          vc_empty,
  output logic [NUM_VC-1:0]          vc_pop,
  input  logic [NUM_DEST-1:0]        dest_afull,
  output logic [NUM_DEST*DATA_W-1:0] dest_data,
  output logic [NUM_DEST-1:0]        dest_push,
  output logic [NUM_VC-1:0]          err_pulse,
  output logic                       err_sticky,
  output logic [CNT_W-1:0]           drop_count
);

  localparam int PTR_W = clog2(NUM_VC);
  // Room for drop_count plus up to NUM_VC (<= 8) simultaneous drops.
  localparam int SUM_W = CNT_W + 4;

  logic [DEST_W-1:0] dest_sel [NUM_VC];
  logic [NUM_VC-1:0] invalid;
  logic [NUM_VC-1:0] req      [NUM_DEST];
  logic [NUM_VC-1:0] grant    [NUM_DEST];
  logic [PTR_W-1:0]  rr_ptr   [NUM_DEST];
  logic [PTR_W-1:0]  next_ptr [NUM_DEST];
  logic [DATA_W-1:0] sel_word [NUM_DEST];
  logic [SUM_W-1:0]  drop_sum;
  logic [CNT_W-1:0]  drop_next;

  // Destination decode; an out-of-range field marks the head word for dropping.
  always_comb begin
    for (int i = 0; i < NUM_VC; i++) begin
      dest_sel[i] = vc_data[i*DATA_W + DEST_LSB +: DEST_W];
      invalid[i]  = !vc_empty[i] && (int'(dest_sel[i]) >= NUM_DEST);
    end
  end

  // Request matrix: a full destination simply sees no request this cycle,
  // so it never holds up VCs heading elsewhere.
  always_comb begin
    for (int d = 0; d < NUM_DEST; d++) begin
      for (int i = 0; i < NUM_VC; i++) begin
        req[d][i] = !vc_empty[i] && !invalid[i] &&
                    (int'(dest_sel[i]) == d) && !dest_afull[d];
      end
    end
  end

  for (genvar g = 0; g < NUM_DEST; g++) begin : g_arb
    rr_arbiter #(
      .N    (NUM_VC),
      .MODE (ARB_MODE)
    ) u_arb (
      .req      (req[g]),
      .ptr      (rr_ptr[g]),
      .grant    (grant[g]),
      .next_ptr (next_ptr[g])
    );
  end

  // Each VC requests a single destination, so the grants are disjoint and
  // OR-ing them cannot pop a VC twice.
  always_comb begin
    vc_pop = invalid;
    for (int d = 0; d < NUM_DEST; d++) vc_pop = vc_pop | grant[d];
    if (reset) vc_pop = '0;
  end

  always_comb begin
    for (int d = 0; d < NUM_DEST; d++) begin
      sel_word[d] = '0;
      for (int i = 0; i < NUM_VC; i++) begin
        if (grant[d][i]) sel_word[d] = sel_word[d] | vc_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Saturating add of all drops seen this cycle.
  always_comb begin
    drop_sum = SUM_W'(drop_count);
    for (int i = 0; i < NUM_VC; i++) drop_sum = drop_sum + SUM_W'(invalid[i]);
    drop_next = (drop_sum > SUM_W'({CNT_W{1'b1}})) ? {CNT_W{1'b1}}
                                                   : drop_sum[CNT_W-1:0];
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the pointer array is small control state and is reset
      // explicitly; it is not a data memory that could be left unreset.
      dest_push  <= '0;
      dest_data  <= '0;
      err_pulse  <= '0;
      err_sticky <= 1'b0;
      drop_count <= '0;
      for (int d = 0; d < NUM_DEST; d++) rr_ptr[d] <= '0;
    end else begin
      err_pulse  <= invalid;
      drop_count <= drop_next;
      if (|invalid) err_sticky <= 1'b1;
      for (int d = 0; d < NUM_DEST; d++) begin
        dest_push[d] <= |grant[d];
        if (|grant[d]) dest_data[d*DATA_W +: DATA_W] <= sel_word[d];
        if (ARB_MODE == ARB_MODE_RR) rr_ptr[d] <= next_ptr[d];
      end
    end
  end

endmodule

// File: tb/tb_vc_dest_router.sv
// Bench for vc_dest_router: three instances (priority, round-robin, and a
// 3-destination round-robin variant with a 2-bit field) share one stimulus
// stream and are each compared every cycle against a behavioural model.
module tb_vc_dest_router;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] vc_data;
  logic [1:0]  vc_empty;
  logic [2:0]  afull;

  logic [1:0]  p0_pop, p0_push, p0_err;  logic [11:0] p0_data; logic p0_sticky; logic [7:0] p0_cnt;
  logic [1:0]  p1_pop, p1_push, p1_err;  logic [11:0] p1_data; logic p1_sticky; logic [7:0] p1_cnt;
  logic [1:0]  p2_pop, p2_err; logic [2:0] p2_push; logic [17:0] p2_data; logic p2_sticky; logic [7:0] p2_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  vc_dest_router #(.ARB_MODE(0)) u_prio (
    .clk(clk), .reset(rst), .vc_data(vc_data), .vc_empty(vc_empty), .vc_pop(p0_pop),
    .dest_afull(afull[1:0]), .dest_data(p0_data), .dest_push(p0_push),
    .err_pulse(p0_err), .err_sticky(p0_sticky), .drop_count(p0_cnt));

  vc_dest_router #(.ARB_MODE(1)) u_rr (
    .clk(clk), .reset(rst), .vc_data(vc_data), .vc_empty(vc_empty), .vc_pop(p1_pop),
    .dest_afull(afull[1:0]), .dest_data(p1_data), .dest_push(p1_push),
    .err_pulse(p1_err), .err_sticky(p1_sticky), .drop_count(p1_cnt));

  vc_dest_router #(.NUM_DEST(3), .DEST_W(2), .ARB_MODE(1)) u_d3 (
    .clk(clk), .reset(rst), .vc_data(vc_data), .vc_empty(vc_empty), .vc_pop(p2_pop),
    .dest_afull(afull), .dest_data(p2_data), .dest_push(p2_push),
    .err_pulse(p2_err), .err_sticky(p2_sticky), .drop_count(p2_cnt));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int cfg_nd(input int j);   return (j == 2) ? 3 : 2; endfunction
  function automatic int cfg_dw(input int j);   return (j == 2) ? 2 : 1; endfunction
  function automatic bit cfg_rr(input int j);   return (j != 0);         endfunction

  function automatic int dest_of(input int j, input int v);
    int word;
    word = int'(vc_data[v*6 +: 6]);
    return (word >> 4) & ((1 << cfg_dw(j)) - 1);
  endfunction

  // Expected registered outputs (what the DUT shows after the last edge).
  logic [3:0] e_push   [3];
  logic [5:0] e_data   [3][4];
  logic [1:0] e_err    [3];
  logic       e_sticky [3];
  int         e_cnt    [3];
  int         m_ptr    [3][4];
  // Per-cycle decisions for the current inputs.
  logic [1:0] m_pop    [3];
  logic [1:0] m_bad    [3];
  int         m_win    [3][4];

  task automatic eval(input int j);
    m_pop[j] = '0;
    m_bad[j] = '0;
    for (int d = 0; d < 4; d++) m_win[j][d] = -1;
    if (!rst) begin
      for (int v = 0; v < 2; v++)
        if (!vc_empty[v] && dest_of(j, v) >= cfg_nd(j)) begin
          m_bad[j][v] = 1'b1;
          m_pop[j][v] = 1'b1;
        end
      for (int d = 0; d < cfg_nd(j); d++) begin
        if (!afull[d]) begin
          for (int k = 0; k < 2; k++) begin
            int v;
            v = cfg_rr(j) ? (m_ptr[j][d] + k) % 2 : k;
            if (m_win[j][d] < 0 && !vc_empty[v] && !m_bad[j][v] && dest_of(j, v) == d)
              m_win[j][d] = v;
          end
        end
        if (m_win[j][d] >= 0) m_pop[j][m_win[j][d]] = 1'b1;
      end
    end
  endtask

  task automatic advance(input int j);
    eval(j);
    if (rst) begin
      e_push[j] = '0; e_err[j] = '0; e_sticky[j] = 1'b0; e_cnt[j] = 0;
      for (int d = 0; d < 4; d++) begin e_data[j][d] = '0; m_ptr[j][d] = 0; end
    end else begin
      e_push[j] = '0;
      for (int d = 0; d < cfg_nd(j); d++) begin
        if (m_win[j][d] >= 0) begin
          e_push[j][d]  = 1'b1;
          e_data[j][d]  = vc_data[m_win[j][d]*6 +: 6];
          if (cfg_rr(j)) m_ptr[j][d] = (m_win[j][d] + 1) % 2;
        end
      end
      e_err[j] = m_bad[j];
      if (m_bad[j] != 0) e_sticky[j] = 1'b1;
      e_cnt[j] = e_cnt[j] + int'(m_bad[j][0]) + int'(m_bad[j][1]);
      if (e_cnt[j] > 255) e_cnt[j] = 255;
    end
  endtask

  task automatic compare(input int j, input logic [1:0] pop, input logic [3:0] push,
                         input logic [23:0] data, input logic [1:0] err,
                         input logic sticky, input logic [7:0] cnt);
    eval(j);
    check($sformatf("u%0d_pop", j), pop, m_pop[j]);
    check($sformatf("u%0d_push", j), push, e_push[j]);
    for (int d = 0; d < cfg_nd(j); d++)
      check($sformatf("u%0d_data%0d", j, d), data[d*6 +: 6], e_data[j][d]);
    check($sformatf("u%0d_err", j), err, e_err[j]);
    check($sformatf("u%0d_sticky", j), sticky, e_sticky[j]);
    check($sformatf("u%0d_cnt", j), cnt, e_cnt[j]);
  endtask

  initial begin
    for (int j = 0; j < 3; j++) begin
      e_push[j] = '0; e_err[j] = '0; e_sticky[j] = 1'b0; e_cnt[j] = 0;
      for (int d = 0; d < 4; d++) begin e_data[j][d] = '0; m_ptr[j][d] = 0; end
    end
    @(posedge clk);
    forever begin
      @(negedge clk);
      compare(0, p0_pop, 4'(p0_push), 24'(p0_data), p0_err, p0_sticky, p0_cnt);
      compare(1, p1_pop, 4'(p1_push), 24'(p1_data), p1_err, p1_sticky, p1_cnt);
      compare(2, p2_pop, 4'(p2_push), 24'(p2_data), p2_err, p2_sticky, p2_cnt);
      for (int j = 0; j < 3; j++) advance(j);
    end
  end

  // ---------------- stimulus and literal expectations ----------------
  task automatic reset_dut();
    @(posedge clk); #1;
    rst = 1'b1; vc_empty = 2'b11; afull = '0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; vc_data = '0; vc_empty = 2'b11; afull = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Both VCs to different destinations: both pop, both pushed next cycle.
    vc_data = {6'b100101, 6'b110100}; vc_empty = 2'b00;
    @(negedge clk);
    check("t1_pop", p0_pop, 2'b11);
    @(posedge clk); #1 vc_empty = 2'b11;
    @(negedge clk);
    check("t1_push", p0_push, 2'b11);
    check("t1_data", p0_data, {6'b110100, 6'b100101});

    // Both VCs to dest 1: priority always picks VC0, round-robin alternates.
    reset_dut();
    vc_data = {6'b110001, 6'b010000}; vc_empty = 2'b00;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("prio_pop", p0_pop, 2'b01);
      check("rr_pop", p1_pop, (k % 2 == 0) ? 2'b01 : 2'b10);
      if (k > 0) check("prio_push", p0_push, 2'b10);
      @(posedge clk); #1;
      check("rr_ptr1", u_rr.rr_ptr[1], (k % 2 == 0) ? 1 : 0);
    end
    vc_empty = 2'b11;
    @(negedge clk);
    check("prio_push_last", p0_push, 2'b10);

    // Dest 0 almost full: VC1 held, VC0 to dest 1 unaffected.
    reset_dut();
    afull = 3'b001; vc_data = {6'b100101, 6'b010000}; vc_empty = 2'b00;
    repeat (2) begin
      @(negedge clk);
      check("afull_pop", p0_pop, 2'b01);
      @(posedge clk); #1;
    end
    afull = 3'b000; vc_empty = 2'b01;
    @(negedge clk);
    check("afull_release_pop", p0_pop, 2'b10);

    // Invalid destination on the 3-destination instance: counter saturates.
    reset_dut();
    vc_data = {6'b000000, 6'b110000}; vc_empty = 2'b10;
    repeat (300) @(posedge clk);
    @(negedge clk);
    check("sat_cnt", p2_cnt, 8'd255);
    check("sat_sticky", p2_sticky, 1'b1);
    check("sat_err", p2_err, 2'b01);

    // Reset in a cycle that would pop: pops suppressed, nothing pushed.
    @(posedge clk); #1;
    rst = 1'b1; vc_data = {6'b100101, 6'b110100}; vc_empty = 2'b00;
    @(negedge clk);
    check("rst_pop0", p0_pop, 2'b00);
    check("rst_pop2", p2_pop, 2'b00);
    @(posedge clk); #1;
    rst = 1'b0; vc_empty = 2'b11;
    @(negedge clk);
    check("rst_push", p0_push, 2'b00);
    check("rst_cnt", p2_cnt, 8'd0);
    check("rst_sticky", p2_sticky, 1'b0);
    check("rst_ptr", {u_rr.rr_ptr[1], u_rr.rr_ptr[0]}, 2'b00);

    // Randomised traffic; the model process checks every cycle.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      vc_data  = 12'($urandom);
      vc_empty = 2'($urandom_range(0, 3));
      afull    = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
      rst      = ($urandom_range(0, 99) == 0);
    end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
